// File: rtl/ofdm_tx_pkg.sv
// ofdm_tx_pkg: shared constants, puncture tables and helpers for the OFDM transmit path.
package ofdm_tx_pkg;

    localparam int K = 7;
    localparam logic [K-1:0] G0 = 7'o133;
    localparam logic [K-1:0] G1 = 7'o171;

    localparam logic [1:0] RATE_1_2 = 2'b00;
    localparam logic [1:0] RATE_2_3 = 2'b01;
    localparam logic [1:0] RATE_3_4 = 2'b10;

    // {keep_a, keep_b} per puncture phase; phase 0 in the low pair
    localparam logic [3:0] PUNCT_2_3 = {2'b10, 2'b11};
    localparam logic [5:0] PUNCT_3_4 = {2'b01, 2'b10, 2'b11};

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_TAIL} enc_state_e;

    function automatic logic [1:0] rate_norm(input logic [1:0] r);
        return (r == 2'b11) ? RATE_1_2 : r;
    endfunction

    // Generator MSB taps the current bit; lower bits tap s[0] (delay 1) downwards
    function automatic logic conv_bit(input logic [K-1:0] g, input logic b, input logic [K-2:0] s);
        logic r;
        r = g[K-1] & b;
        for (int i = 0; i < K-1; i++) r ^= g[K-2-i] & s[i];
        return r;
    endfunction

endpackage

// File: rtl/conv_encoder_tx_if.sv
// conv_encoder_tx_if: serial data input and coded pair output streams of the encoder.
interface conv_encoder_tx_if;
    logic       di_valid;
    logic       di_ready;
    logic       di_bit;
    logic       di_last;
    logic [1:0] di_rate;
    logic       do_valid;
    logic       do_ready;
    logic       do_a;
    logic       do_b;
    logic [1:0] do_keep;
    logic       do_last;

    modport master (
        output di_valid, di_bit, di_last, di_rate, do_ready,
        input  di_ready, do_valid, do_a, do_b, do_keep, do_last
    );

    modport slave (
        input  di_valid, di_bit, di_last, di_rate, do_ready,
        output di_ready, do_valid, do_a, do_b, do_keep, do_last
    );
endinterface

// File: rtl/conv_punct_gen.sv
// conv_punct_gen: puncture phase counter producing the {keep_a, keep_b} mask for each encode step.
module conv_punct_gen
    import ofdm_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] rate_i,
    input  logic       step_i,
    input  logic       start_i,
    output logic [1:0] keep_o
);

    logic [1:0] phase_q, phase_d, ph, ph_last;

    // Frame start forces phase 0 for the step that opens the frame
    always_comb begin
        ph      = start_i ? 2'd0 : phase_q;
        ph_last = (rate_i == RATE_2_3) ? 2'd1 : (rate_i == RATE_3_4) ? 2'd2 : 2'd0;
        phase_d = !step_i ? phase_q : (ph == ph_last) ? 2'd0 : ph + 2'd1;
        keep_o  = (rate_i == RATE_2_3) ? PUNCT_2_3[{ph[0], 1'b0} +: 2] :
                  (rate_i == RATE_3_4) ? PUNCT_3_4[{ph, 1'b0} +: 2] : 2'b11;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) phase_q <= 2'd0;
        else        phase_q <= phase_d;

endmodule

// File: rtl/conv_encoder_tx.sv
// conv_encoder_tx: K=7 rate-1/2 convolutional encoder (133/171) with zero tail and puncture keep mask.
module conv_encoder_tx
    import ofdm_tx_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    conv_encoder_tx_if.slave bus
);

    enc_state_e state_q;
    logic [K-2:0] sr_q;
    logic [2:0]   tail_q;
    logic [1:0]   rate_q, rate_d, keep;
    logic         do_valid_q, do_a_q, do_b_q, do_last_q;
    logic [1:0]   do_keep_q;
    logic         advance, xfer, step, start, b;

    assign advance = !do_valid_q || bus.do_ready;
    assign bus.di_ready = advance && (state_q != ST_TAIL) && rst_n;
    assign xfer  = bus.di_valid && bus.di_ready;
    assign step  = xfer || (state_q == ST_TAIL && advance);
    assign start = xfer && (state_q == ST_IDLE);
    assign b     = (state_q == ST_TAIL) ? 1'b0 : bus.di_bit;
    assign rate_d = start ? rate_norm(bus.di_rate) : rate_q;

    conv_punct_gen u_punct (
        .clk    (clk),
        .rst_n  (rst_n),
        .rate_i (rate_d),
        .step_i (step),
        .start_i(start),
        .keep_o (keep)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            tail_q     <= '0;
            rate_q     <= RATE_1_2;
            do_valid_q <= 1'b0;
            do_a_q     <= 1'b0;
            do_b_q     <= 1'b0;
            do_keep_q  <= 2'b00;
            do_last_q  <= 1'b0;
        end else begin
            rate_q <= rate_d;
            if (advance) do_valid_q <= step;
            if (step) begin
                do_a_q    <= conv_bit(G0, b, sr_q);
                do_b_q    <= conv_bit(G1, b, sr_q);
                do_keep_q <= keep;
                do_last_q <= (state_q == ST_TAIL) && (tail_q == 3'(K-2));
                sr_q      <= {sr_q[K-3:0], b};
            end
            case (state_q)
                ST_IDLE: begin
                    tail_q <= '0;
                    if (xfer) state_q <= bus.di_last ? ST_TAIL : ST_DATA;
                    else      sr_q    <= '0;
                end
                ST_DATA: if (xfer && bus.di_last) begin
                    state_q <= ST_TAIL;
                    tail_q  <= '0;
                end
                ST_TAIL: if (advance) begin
                    tail_q <= tail_q + 3'd1;
                    if (tail_q == 3'(K-2)) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.do_valid = do_valid_q;
    assign bus.do_a     = do_a_q;
    assign bus.do_b     = do_b_q;
    assign bus.do_keep  = do_keep_q;
    assign bus.do_last  = do_last_q;

endmodule

// File: tb/tb_conv_encoder_tx.sv
// tb_conv_encoder_tx: directed checks of the convolutional encoder, tail, puncture mask and handshake.
module tb_conv_encoder_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    logic       q_bit[$];
    logic       q_last[$];
    logic [1:0] q_rate[$];
    logic [4:0] q_exp[$];
    bit         bp;

    conv_encoder_tx_if bus ();

    conv_encoder_tx u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic xb(input logic [15:0] bits, input int n, input int m);
        return (m >= 0 && m < n) ? bits[m] : 1'b0;
    endfunction

    // Reference: A taps delays 0,2,3,5,6; B taps delays 0,1,2,3,6; six zero tail bits
    function automatic void add_frame(input logic [15:0] bits, input int n, input logic [1:0] rate);
        logic a, bb;
        logic [1:0] kp;
        for (int i = 0; i < n; i++) begin
            q_bit.push_back(bits[i]);
            q_last.push_back(i == n - 1);
            q_rate.push_back(rate);
        end
        for (int j = 0; j < n + 6; j++) begin
            a  = xb(bits, n, j) ^ xb(bits, n, j-2) ^ xb(bits, n, j-3) ^ xb(bits, n, j-5) ^ xb(bits, n, j-6);
            bb = xb(bits, n, j) ^ xb(bits, n, j-1) ^ xb(bits, n, j-2) ^ xb(bits, n, j-3) ^ xb(bits, n, j-6);
            kp = (rate == 2'b01) ? ((j % 2 == 0) ? 2'b11 : 2'b10) :
                 (rate == 2'b10) ? ((j % 3 == 0) ? 2'b11 : (j % 3 == 1) ? 2'b10 : 2'b01) : 2'b11;
            q_exp.push_back({a, bb, kp, j == n + 5});
        end
    endfunction

    task automatic clear_q();
        q_bit.delete();
        q_last.delete();
        q_rate.delete();
        q_exp.delete();
    endtask

    task automatic impulse(input string tag, input logic [1:0] r, input logic [13:0] kexp);
        logic [6:0] ea, eb;
        ea = 7'b1011011;
        eb = 7'b1111001;
        @(negedge clk);
        bus.do_ready = 1'b1;
        bus.di_valid = 1'b1;
        bus.di_bit   = 1'b1;
        bus.di_last  = 1'b1;
        bus.di_rate  = r;
        #1 chk($sformatf("%s_rdy_in", tag), bus.di_ready, 1);
        @(negedge clk);
        bus.di_valid = 1'b0;
        bus.di_bit   = 1'b0;
        bus.di_last  = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk($sformatf("%s_pair%0d", tag, i),
                {bus.do_valid, bus.do_a, bus.do_b, bus.do_keep, bus.do_last},
                {1'b1, ea[6-i], eb[6-i], kexp[13-2*i -: 2], i == 6});
            chk($sformatf("%s_rdy%0d", tag, i), bus.di_ready, i == 6);
        end
        @(negedge clk);
        #1 chk($sformatf("%s_idle", tag), bus.do_valid, 0);
    endtask

    task automatic stream(input string tag);
        int idx = 0, k = 0, c = 0;
        logic hold = 1'b0;
        logic [4:0] held = '0, got;
        while (k < q_exp.size() && c < 400) begin
            @(negedge clk);
            bus.do_ready = bp ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
            bus.di_valid = idx < q_bit.size();
            bus.di_bit   = (idx < q_bit.size()) ? q_bit[idx] : 1'b0;
            bus.di_last  = (idx < q_bit.size()) ? q_last[idx] : 1'b0;
            bus.di_rate  = (idx < q_rate.size()) ? q_rate[idx] : 2'b00;
            #1;
            got = {bus.do_a, bus.do_b, bus.do_keep, bus.do_last};
            if (hold) chk($sformatf("%s_hold%0d", tag, k), {bus.do_valid, got}, {1'b1, held});
            hold = bus.do_valid && !bus.do_ready;
            held = got;
            if (bus.do_valid && bus.do_ready) begin
                chk($sformatf("%s_pair%0d", tag, k), got, q_exp[k]);
                k++;
                if (k == q_exp.size() && !bp) chk($sformatf("%s_cycles", tag), c, k);
            end
            if (bus.di_valid && bus.di_ready) idx++;
            c++;
        end
        chk($sformatf("%s_npairs", tag), k, q_exp.size());
        chk($sformatf("%s_nbits", tag), idx, q_bit.size());
        @(negedge clk);
        bus.di_valid = 1'b0;
        bus.do_ready = 1'b1;
        #1 chk($sformatf("%s_idle", tag), bus.do_valid, 0);
    endtask

    initial begin
        bus.di_valid = 1'b1;
        bus.di_bit   = 1'b1;
        bus.di_last  = 1'b0;
        bus.di_rate  = 2'b00;
        bus.do_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outs", {bus.do_valid, bus.do_a, bus.do_b, bus.do_keep, bus.do_last, bus.di_ready}, 0);
        bus.di_valid = 1'b0;
        rst_n = 1'b1;
        #1 chk("reset_rdy", bus.di_ready, 1);

        impulse("imp12", 2'b00, 14'b11_11_11_11_11_11_11);
        impulse("imp34", 2'b10, 14'b11_10_01_11_10_01_11);

        clear_q();
        add_frame(16'b0000_0010_1100_1110, 10, 2'b00);
        bp = 1'b1;
        stream("bp");

        clear_q();
        add_frame(16'b0000_0000_0000_1101, 4, 2'b01);
        for (int i = 1; i < 4; i++) q_rate[i] = 2'b00;
        add_frame(16'b0000_0000_0000_0011, 2, 2'b00);
        bp = 1'b0;
        stream("b2b");

        @(negedge clk);
        bus.do_ready = 1'b1;
        bus.di_valid = 1'b1;
        bus.di_bit   = 1'b1;
        bus.di_last  = 1'b0;
        bus.di_rate  = 2'b00;
        repeat (2) @(negedge clk);
        #1 chk("pre_rst", {bus.do_valid, bus.do_a, bus.do_b, bus.do_keep, bus.do_last}, 6'b1_1_0_11_0);
        rst_n = 1'b0;
        #1 chk("mid_rst", {bus.do_valid, bus.do_a, bus.do_b, bus.do_keep, bus.do_last, bus.di_ready}, 0);
        @(negedge clk);
        bus.di_valid = 1'b0;
        rst_n = 1'b1;
        impulse("imp_after_rst", 2'b00, 14'b11_11_11_11_11_11_11);

        impulse("imp_rsv", 2'b11, 14'b11_11_11_11_11_11_11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
